// File: rtl/fp32_divider_iter.sv
// Iterative IEEE-754 binary32 divider: restoring shift-subtract, one quotient bit per clock.
// Define FPDIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp32_divider_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_vld,
    output logic        o_busy,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    output logic        overflow,
    output logic        o_div_by_zero
);
    localparam int unsigned MAN_W = 24;
    localparam int unsigned Q_W   = 26;
    localparam int unsigned R_W   = 25;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned E_W   = 10;
    localparam logic [31:0] QNAN  = 32'h7FC00000;

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [Q_W-1:0]         q_q, q_d;
    logic [R_W-1:0]         r_q, r_d;
    logic [MAN_W-1:0]       d_q, d_d;
    logic signed [E_W-1:0]  e_q, e_d;
    logic                   sign_q, sign_d;
    logic [31:0]            res_q, res_d;
    logic                   res_ovf_q, res_ovf_d;
    logic                   res_dbz_q, res_dbz_d;
    logic                   busy_q, busy_d;
    logic [31:0]            o_res_q, o_res_d;
    logic                   o_res_vld_q, o_res_vld_d;
    logic                   overflow_q, overflow_d;
    logic                   o_div_by_zero_q, o_div_by_zero_d;

    // Operand classification (denormals flush to zero)
    logic [7:0] exp_a, exp_b;
    logic       zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_ab;

    always_comb begin
        exp_a   = i_a[30:23];
        exp_b   = i_b[30:23];
        zero_a  = (exp_a == 8'h00);
        zero_b  = (exp_b == 8'h00);
        inf_a   = (exp_a == 8'hFF) && (i_a[22:0] == '0);
        inf_b   = (exp_b == 8'hFF) && (i_b[22:0] == '0);
        nan_a   = (exp_a == 8'hFF) && (i_a[22:0] != '0);
        nan_b   = (exp_b == 8'hFF) && (i_b[22:0] != '0);
        sign_ab = i_a[31] ^ i_b[31];
    end

    // Normalize, round and pack the finished quotient
    logic [MAN_W-1:0]      mant;
    logic signed [E_W-1:0] e_n, e_fin;
    logic [22:0]           frac_fin;
    logic [31:0]           norm_res;
    logic                  norm_ovf;
`ifdef FPDIV_ROUND_EN
    logic                  guard, sticky;
    logic [MAN_W:0]        mant_r;
`else
    logic                  unused_rnd_bits;
    assign unused_rnd_bits = ^{q_q[0], mant[MAN_W-1]};
`endif

    always_comb begin
        mant = q_q[Q_W-1] ? q_q[25:2] : q_q[24:1];
        e_n  = q_q[Q_W-1] ? e_q : e_q - 10'sd1;
`ifdef FPDIV_ROUND_EN
        guard  = q_q[Q_W-1] ? q_q[1] : q_q[0];
        sticky = (q_q[Q_W-1] & q_q[0]) | (r_q != '0);
        mant_r = {1'b0, mant} + R_W'(guard & (sticky | mant[0]));
        if (mant_r[MAN_W]) begin
            frac_fin = mant_r[23:1];
            e_fin    = e_n + 10'sd1;
        end else begin
            frac_fin = mant_r[22:0];
            e_fin    = e_n;
        end
`else
        frac_fin = mant[22:0];
        e_fin    = e_n;
`endif
        norm_res = {sign_q, e_fin[7:0], frac_fin};
        norm_ovf = 1'b0;
        if (e_fin >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'h0};
            norm_ovf = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            norm_res = {sign_q, 31'h0};
        end
    end

    logic [MAN_W-1:0] r_sub;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        q_d             = q_q;
        r_d             = r_q;
        d_d             = d_q;
        e_d             = e_q;
        sign_d          = sign_q;
        res_d           = res_q;
        res_ovf_d       = res_ovf_q;
        res_dbz_d       = res_dbz_q;
        busy_d          = busy_q;
        o_res_d         = '0;
        o_res_vld_d     = 1'b0;
        overflow_d      = 1'b0;
        o_div_by_zero_d = 1'b0;
        r_sub           = '0;
        case (state_q)
            S_IDLE: begin
                if (i_vld) begin
                    busy_d    = 1'b1;
                    sign_d    = sign_ab;
                    res_d     = '0;
                    res_ovf_d = 1'b0;
                    res_dbz_d = 1'b0;
                    state_d   = S_DONE;
                    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
                        res_d     = QNAN;
                        res_ovf_d = 1'b1;
                    end else if (inf_a) begin
                        res_d     = {sign_ab, 8'hFF, 23'h0};
                        res_ovf_d = 1'b1;
                    end else if (inf_b) begin
                        res_d     = {sign_ab, 31'h0};
                    end else if (zero_b) begin
                        res_d     = {sign_ab, 8'hFF, 23'h0};
                        res_ovf_d = 1'b1;
                        res_dbz_d = 1'b1;
                    end else if (zero_a) begin
                        res_d     = {sign_ab, 31'h0};
                    end else begin
                        r_d     = R_W'({1'b1, i_a[22:0]});
                        d_d     = {1'b1, i_b[22:0]};
                        q_d     = '0;
                        cnt_d   = CNT_W'(Q_W - 1);
                        e_d     = E_W'(exp_a) - E_W'(exp_b) + E_W'(127);
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                // R < 2D always holds, so the difference fits in 24 bits before the shift
                if (r_q >= R_W'(d_q)) begin
                    q_d[cnt_q] = 1'b1;
                    r_sub      = MAN_W'(r_q - R_W'(d_q));
                end else begin
                    q_d[cnt_q] = 1'b0;
                    r_sub      = MAN_W'(r_q);
                end
                r_d = {r_sub, 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NORM: begin
                res_d     = norm_res;
                res_ovf_d = norm_ovf;
                res_dbz_d = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                o_res_d         = res_q;
                o_res_vld_d     = 1'b1;
                overflow_d      = res_ovf_q;
                o_div_by_zero_d = res_dbz_q;
                busy_d          = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            q_q             <= '0;
            r_q             <= '0;
            d_q             <= '0;
            e_q             <= '0;
            sign_q          <= 1'b0;
            res_q           <= '0;
            res_ovf_q       <= 1'b0;
            res_dbz_q       <= 1'b0;
            busy_q          <= 1'b0;
            o_res_q         <= '0;
            o_res_vld_q     <= 1'b0;
            overflow_q      <= 1'b0;
            o_div_by_zero_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            q_q             <= q_d;
            r_q             <= r_d;
            d_q             <= d_d;
            e_q             <= e_d;
            sign_q          <= sign_d;
            res_q           <= res_d;
            res_ovf_q       <= res_ovf_d;
            res_dbz_q       <= res_dbz_d;
            busy_q          <= busy_d;
            o_res_q         <= o_res_d;
            o_res_vld_q     <= o_res_vld_d;
            overflow_q      <= overflow_d;
            o_div_by_zero_q <= o_div_by_zero_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_res         = o_res_q;
    assign o_res_vld     = o_res_vld_q;
    assign overflow      = overflow_q;
    assign o_div_by_zero = o_div_by_zero_q;

endmodule

// File: doc/fp32_divider_iter.md
# fp32_divider_iter

Iterative IEEE-754 single-precision divider (`i_a / i_b`), the inverse-operation companion to the FPU's single-cycle multiplier. It shares the same operand unpacking, special-value encoding and `overflow` flag semantics. The mantissa quotient is produced by a restoring shift-subtract loop at one bit per clock, behind a valid/busy handshake. It sits in the FPU datapath beside the multiplier and adder.

## Interface
- No parameters.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_a` in 32: dividend, IEEE-754 binary32.
- `i_b` in 32: divisor, IEEE-754 binary32.
- `i_vld` in 1: operands valid; sampled only when `o_busy`=0.
- `o_busy` out 1: operation in flight; `i_vld` is ignored while high.
- `o_res` out 32: quotient; 0 whenever `o_res_vld`=0.
- `o_res_vld` out 1: one-cycle pulse, `o_res` valid.
- `overflow` out 1: valid with `o_res_vld`; 1 for NaN, Inf or exponent-overflow results; 0 otherwise.
- `o_div_by_zero` out 1: valid with `o_res_vld`; 1 when finite nonzero / zero.

## Operation
- Unpack each operand into sign, exp[7:0] and man[23:0] with the hidden 1. `exp==0` is treated as zero; denormal inputs are flushed to zero.
- Result sign is `sign_a ^ sign_b` for every result, including zero and Inf. The default NaN is positive.
- Special cases are resolved in IDLE and bypass DIVIDE. They are checked in priority order:
  1. Either operand NaN, 0/0, or Inf/Inf: `32'h7FC00000`, overflow=1.
  2. Inf/x: signed Inf, overflow=1.
  3. x/Inf: signed zero, overflow=0.
  4. x/0: signed Inf, overflow=1, div_by_zero=1.
  5. 0/x: signed zero, overflow=0.
- States:
  - IDLE: accepts operands on `i_vld`. A special case goes to DONE; otherwise load R=man_a, D=man_b, Q=0, cnt=25 and go to DIVIDE.
  - DIVIDE: 26 cycles. Each cycle, if R≥D then Q[cnt]=1 and R=R−D, else Q[cnt]=0. Then R<<=1 and cnt−=1. Exit to NORM after cnt=0. R is 25 bits wide.
  - NORM: normalize, round and pack, then go to DONE.
  - DONE: assert `o_res_vld` for one cycle and return to IDLE.
- The quotient satisfies Q∈[2^24, 2^26).
  - If Q[25]=1: mantissa=Q[25:2], guard=Q[1], sticky=Q[0]|(R≠0), e=ea−eb+127.
  - Else: mantissa=Q[24:1], guard=Q[0], sticky=(R≠0), e=ea−eb+126.
- e is a signed 10-bit value. If rounding carries the mantissa to 2^24, shift it right by one and set e+=1.
- If e≥255 after rounding: signed Inf, overflow=1.
- If e≤0: signed zero, overflow=0 (no denormal output).
- Otherwise: `{sign, e[7:0], mantissa[22:0]}`.

## Timing
- Reset values: `o_res`=0, `o_res_vld`=0, `overflow`=0, `o_div_by_zero`=0, `o_busy`=0, state=IDLE. Q, R and cnt are cleared.
- An accept at edge 0 (`i_vld`=1, `o_busy`=0) drives `o_busy`=1 from edge 0.
- Normal path: DIVIDE occupies edges 1–26, NORM runs at edge 27, and `o_res`/`o_res_vld` are registered at edge 28. Latency is 28 cycles.
- Special path: result registered at edge 1. Latency is 1 cycle.
- `o_busy` falls at the same edge that raises `o_res_vld`. The earliest next accept is that edge plus one.
- At the edge after the pulse, `o_res_vld`, `o_res`, `overflow` and `o_div_by_zero` return to 0.
- `i_vld` while busy: dropped, with no side effect on operands in flight.
- `rst` in any state: immediate return to IDLE and reset values. The in-flight operation is discarded and no `o_res_vld` is produced.
- `rst` and `i_vld` in the same cycle: reset wins; the operands are not accepted.

## Configuration
- `FPDIV_ROUND_EN` defined: round-to-nearest-even. Increment the mantissa when guard & (sticky | mantissa[0]).
- `FPDIV_ROUND_EN` undefined: truncate. Guard and sticky are ignored, and no rounding incrementer is synthesized.

## Test plan
- `40C00000`/`40000000` (6/2), accepted at edge 0 → `o_res`=`40400000` at edge 28; overflow=0; `o_busy` high for edges 0–27.
- `3F800000`/`40400000` (1/3) → `3EAAAAAB` with `FPDIV_ROUND_EN` defined, `3EAAAAAA` without it.
- `BF800000`/`00000000` → `FF800000` at edge 1; overflow=1, div_by_zero=1. `00000000`/`00000000` → `7FC00000`, overflow=1, div_by_zero=0.
- `7F7FFFFF`/`3F000000` → `7F800000`, overflow=1. `00800000`/`4B000000` → `00000000`, overflow=0.
- Second `i_vld` with different operands at edge 10 of an operation → ignored; first result intact; exactly one `o_res_vld` pulse.
- `rst` at edge 15 of a 6/2 operation → all outputs 0 at the next edge; no `o_res_vld`; a new accept 1 cycle later completes normally.
